// File: rtl/vector_writeback_unit_pkg.sv
// Shared encodings for the vector writeback unit: FU status, element width,
// FSM states and beat-count derivation.
package vector_writeback_unit_pkg;

    typedef enum logic [1:0] {
        VEC_ALU_NOP      = 2'd0,
        VEC_ALU_WORKING  = 2'd1,
        VEC_ALU_FINISHED = 2'd2
    } alu_status_e;

    typedef enum logic [2:0] {
        ONE_BYTE   = 3'd0,
        TWO_BYTE   = 3'd1,
        FOUR_BYTE  = 3'd2,
        EIGHT_BYTE = 3'd3
    } vsew_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MERGE = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } wb_state_e;

    function automatic int unsigned nbeats(input int unsigned vlen, input int unsigned beat_width);
        return vlen / beat_width;
    endfunction

    // log2 of element size in bytes; unknown widths fall back to 32-bit elements
    function automatic int unsigned sew_shift(input logic [2:0] vsew);
        case (vsew)
            ONE_BYTE:   return 0;
            TWO_BYTE:   return 1;
            EIGHT_BYTE: return 3;
            default:    return 2;
        endcase
    endfunction

    function automatic logic sew_known(input logic [2:0] vsew);
        return (vsew == ONE_BYTE) || (vsew == TWO_BYTE) ||
               (vsew == FOUR_BYTE) || (vsew == EIGHT_BYTE);
    endfunction

endpackage

// File: rtl/vector_writeback_unit_merge_lane.sv
// Combinational body/tail/mask merge of a result vector into the old destination.
// VWB_TAIL_AGNOSTIC_EN: tail elements become all-ones instead of old_vd.
module vector_merge_lane
    import vector_writeback_unit_pkg::*;
#(
    parameter int unsigned VLEN = 256,
    parameter int unsigned VL_W = 4
) (
    input  logic [VLEN-1:0] result,
    input  logic [VLEN-1:0] old_vd,
    input  logic [VLEN-1:0] mask,
    input  logic            is_mask,
    input  logic [2:0]      vsew,
    input  logic [VL_W-1:0] vl,
    input  logic            vm,
    output logic [VLEN-1:0] merged
);

    localparam int unsigned NBYTES = VLEN / 8;

    logic [VLEN-1:0] mask_sh;
    int unsigned     shift;

    always_comb begin
        merged  = old_vd;
        mask_sh = '0;
        shift   = sew_shift(vsew);
        if (is_mask) begin
            for (int unsigned i = 0; i < VLEN; i++) begin
                if (i < 32'(vl)) begin
                    merged[i] = result[i];
                end
`ifdef VWB_TAIL_AGNOSTIC_EN
                else begin
                    merged[i] = 1'b1;
                end
`endif
            end
        end else begin
            // walk bytes; element index of byte k is k >> log2(element bytes)
            for (int unsigned k = 0; k < NBYTES; k++) begin
                mask_sh = mask >> (k >> shift);
                if ((k >> shift) < 32'(vl)) begin
                    if (vm || mask_sh[0]) begin
                        merged[k*8 +: 8] = result[k*8 +: 8];
                    end
                end
`ifdef VWB_TAIL_AGNOSTIC_EN
                else begin
                    merged[k*8 +: 8] = '1;
                end
`endif
            end
        end
    end

endmodule

// File: rtl/vector_writeback_unit.sv
// Captures a finished vector result, merges it with the old destination and
// streams it to the register file in BEAT_WIDTH beats. Option: VWB_TAIL_AGNOSTIC_EN.
module vector_writeback_unit
    import vector_writeback_unit_pkg::*;
#(
    parameter int unsigned VECTOR_SIZE      = 8,
    parameter int unsigned LEN              = 32,
    parameter int unsigned ENTRY_INDEX_SIZE = 3,
    parameter int unsigned BEAT_WIDTH       = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [1:0]                            alu_status,
    input  logic [VECTOR_SIZE*LEN-1:0]            alu_result,
    input  logic                                  is_mask,
    input  logic [2:0]                            vsew,
    input  logic [ENTRY_INDEX_SIZE:0]             vl,
    input  logic                                  vm,
    input  logic [VECTOR_SIZE*LEN-1:0]            mask,
    input  logic [VECTOR_SIZE*LEN-1:0]            old_vd,
    input  logic [4:0]                            vd_index,
    input  logic                                  wb_ready,
    output logic                                  wb_valid,
    output logic [4:0]                            wb_index,
    output logic [1:0]                            wb_beat,
    output logic [BEAT_WIDTH-1:0]                 wb_data,
    output logic                                  busy,
    output logic                                  wb_done,
    output logic                                  overrun
);

    localparam int unsigned VLEN      = VECTOR_SIZE * LEN;
    localparam int unsigned NBEATS    = nbeats(VLEN, BEAT_WIDTH);
    localparam logic [1:0]  LAST_BEAT = 2'(NBEATS - 1);

    wb_state_e                 state;
    logic [1:0]                prev_status;
    logic [VLEN-1:0]           res_q, old_q, mask_q, merged, merged_q;
    logic                      is_mask_q, vm_q;
    logic [2:0]                vsew_q;
    logic [ENTRY_INDEX_SIZE:0] vl_q;
    logic                      fin_edge;
    logic [BEAT_WIDTH-1:0]     next_data;

    assign fin_edge  = (alu_status == VEC_ALU_FINISHED) && (prev_status != VEC_ALU_FINISHED);
    assign next_data = BEAT_WIDTH'(merged_q >> ((32'(wb_beat) + 32'd1) * BEAT_WIDTH));

    vector_merge_lane #(
        .VLEN (VLEN),
        .VL_W (ENTRY_INDEX_SIZE + 1)
    ) u_merge (
        .result  (res_q),
        .old_vd  (old_q),
        .mask    (mask_q),
        .is_mask (is_mask_q),
        .vsew    (vsew_q),
        .vl      (vl_q),
        .vm      (vm_q),
        .merged  (merged)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            prev_status <= '0;
            res_q       <= '0;
            old_q       <= '0;
            mask_q      <= '0;
            merged_q    <= '0;
            is_mask_q   <= 1'b0;
            vm_q        <= 1'b0;
            vsew_q      <= '0;
            vl_q        <= '0;
            wb_valid    <= 1'b0;
            wb_index    <= '0;
            wb_beat     <= '0;
            wb_data     <= '0;
            busy        <= 1'b0;
            wb_done     <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            prev_status <= alu_status;
            // any fresh completion outside IDLE (DONE included) is dropped and flagged
            if (fin_edge && state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (fin_edge) begin
                        res_q     <= alu_result;
                        old_q     <= old_vd;
                        mask_q    <= mask;
                        is_mask_q <= is_mask;
                        vm_q      <= vm;
                        vsew_q    <= vsew;
                        vl_q      <= vl;
                        wb_index  <= vd_index;
                        busy      <= 1'b1;
                        state     <= S_MERGE;
                    end
                end
                S_MERGE: begin
                    merged_q <= merged;
                    wb_data  <= merged[BEAT_WIDTH-1:0];
                    wb_beat  <= '0;
                    wb_valid <= 1'b1;
                    state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (wb_ready) begin
                        if (wb_beat == LAST_BEAT) begin
                            wb_valid <= 1'b0;
                            wb_done  <= 1'b1;
                            state    <= S_DONE;
                        end else begin
                            wb_beat <= wb_beat + 2'd1;
                            wb_data <= next_data;
                        end
                    end
                end
                S_DONE: begin
                    wb_done <= 1'b0;
                    busy    <= 1'b0;
                    state   <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst && state == S_IDLE && fin_edge) begin
            assert (sew_known(vsew))
            else $error("vector_writeback_unit: unsupported vsew %0d, merging as FOUR_BYTE", vsew);
        end
    end

endmodule

// File: tb/tb_vector_writeback_unit.sv
// Directed self-checking bench for vector_writeback_unit (default and
// VWB_TAIL_AGNOSTIC_EN builds).
module tb_vector_writeback_unit;
    import vector_writeback_unit_pkg::*;

    logic         clk;
    logic         rst;
    logic [1:0]   alu_status;
    logic [255:0] alu_result;
    logic         is_mask;
    logic [2:0]   vsew;
    logic [3:0]   vl;
    logic         vm;
    logic [255:0] mask;
    logic [255:0] old_vd;
    logic [4:0]   vd_index;
    logic         wb_ready;
    logic         wb_valid;
    logic [4:0]   wb_index;
    logic [1:0]   wb_beat;
    logic [63:0]  wb_data;
    logic         busy;
    logic         wb_done;
    logic         overrun;

    int checks = 0;
    int passes = 0;
    int fails  = 0;

    logic [255:0] exp_vec;
    logic [255:0] pat;

    vector_writeback_unit #(
        .VECTOR_SIZE      (8),
        .LEN              (32),
        .ENTRY_INDEX_SIZE (3),
        .BEAT_WIDTH       (64)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .alu_status (alu_status),
        .alu_result (alu_result),
        .is_mask    (is_mask),
        .vsew       (vsew),
        .vl         (vl),
        .vm         (vm),
        .mask       (mask),
        .old_vd     (old_vd),
        .vd_index   (vd_index),
        .wb_ready   (wb_ready),
        .wb_valid   (wb_valid),
        .wb_index   (wb_index),
        .wb_beat    (wb_beat),
        .wb_data    (wb_data),
        .busy       (busy),
        .wb_done    (wb_done),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // drive one operation and present a single FINISHED edge; returns #1 after capture edge
    task automatic start(input logic [2:0] s, input logic [3:0] l, input logic m, input logic mop,
                         input logic [255:0] res, input logic [255:0] old, input logic [255:0] msk,
                         input logic [4:0] idx);
        vsew       = s;
        vl         = l;
        vm         = m;
        is_mask    = mop;
        alu_result = res;
        old_vd     = old;
        mask       = msk;
        vd_index   = idx;
        alu_status = VEC_ALU_FINISHED;
        tick();
        alu_status = VEC_ALU_NOP;
    endtask

    // expects beat 0 already presented; walks all four beats with wb_ready high
    task automatic stream(input string tag, input logic [255:0] e, input logic [4:0] idx);
        for (int b = 0; b < 4; b++) begin
            check({tag, "_valid"}, 64'(wb_valid), 64'd1);
            check({tag, "_beat"},  64'(wb_beat),  64'(b));
            check({tag, "_data"},  wb_data,       e[b*64 +: 64]);
            check({tag, "_index"}, 64'(wb_index), 64'(idx));
            tick();
        end
    endtask

    initial begin
        rst        = 1'b0;
        alu_status = VEC_ALU_NOP;
        alu_result = '0;
        is_mask    = 1'b0;
        vsew       = FOUR_BYTE;
        vl         = '0;
        vm         = 1'b1;
        mask       = '0;
        old_vd     = '0;
        vd_index   = '0;
        wb_ready   = 1'b1;
        tick();
        tick();
        check("rst_valid", 64'(wb_valid), 64'd0);
        check("rst_busy",  64'(busy),     64'd0);
        check("rst_done",  64'(wb_done),  64'd0);
        check("rst_ovr",   64'(overrun),  64'd0);
        check("rst_beat",  64'(wb_beat),  64'd0);
        check("rst_index", 64'(wb_index), 64'd0);
        check("rst_data",  wb_data,       64'd0);
        rst = 1'b1;
        tick();

        // FOUR_BYTE, all elements active, full-rate handshake
        pat = {32{8'h11}};
        start(FOUR_BYTE, 4'd8, 1'b1, 1'b0, pat, {32{8'h22}}, '0, 5'd7);
        check("s1_busy_merge",  64'(busy),     64'd1);
        check("s1_valid_merge", 64'(wb_valid), 64'd0);
        tick();
        stream("s1", pat, 5'd7);
        check("s1_done",       64'(wb_done),  64'd1);
        check("s1_valid_done", 64'(wb_valid), 64'd0);
        check("s1_busy_done",  64'(busy),     64'd1);
        tick();
        check("s1_done_clr", 64'(wb_done), 64'd0);
        check("s1_busy_clr", 64'(busy),    64'd0);
        check("s1_no_ovr",   64'(overrun), 64'd0);

        // masked, vm=0, mask=0x55
        start(FOUR_BYTE, 4'd8, 1'b0, 1'b0, {32{8'h11}}, '0, 256'h55, 5'd3);
        tick();
        check("s2_beat0", wb_data, 64'h0000000011111111);
        tick();
        check("s2_beat1", wb_data, 64'h0000000011111111);
        tick(); tick(); tick(); tick();

        // ONE_BYTE, vl=3: tail handling
        start(ONE_BYTE, 4'd3, 1'b1, 1'b0, {32{8'hAB}}, '0, '0, 5'd9);
        tick();
`ifdef VWB_TAIL_AGNOSTIC_EN
        check("s3_beat0", wb_data, 64'hFFFFFFFFFFABABAB);
        tick();
        check("s3_beat1", wb_data, 64'hFFFFFFFFFFFFFFFF);
`else
        check("s3_beat0", wb_data, 64'h0000000000ABABAB);
        tick();
        check("s3_beat1", wb_data, 64'h0000000000000000);
`endif
        tick(); tick(); tick(); tick();

        // mask-type result, vl=4
        start(FOUR_BYTE, 4'd4, 1'b1, 1'b1, '1, '0, '0, 5'd0);
        tick();
`ifdef VWB_TAIL_AGNOSTIC_EN
        check("s4_beat0", wb_data, 64'hFFFFFFFFFFFFFFFF);
`else
        check("s4_beat0", wb_data, 64'h000000000000000F);
`endif
        tick(); tick(); tick(); tick(); tick();
        check("s4_no_ovr", 64'(overrun), 64'd0);

        // stall on beat 1 with a second FINISHED edge during the stall
        pat = {{16{4'hD}}, {16{4'hC}}, {16{4'hB}}, {16{4'hA}}};
        start(FOUR_BYTE, 4'd8, 1'b1, 1'b0, pat, '0, '0, 5'd21);
        tick();
        check("s5_beat0", wb_data, pat[63:0]);
        tick();
        wb_ready   = 1'b0;
        alu_result = '0;
        alu_status = VEC_ALU_FINISHED;
        for (int c = 0; c < 3; c++) begin
            tick();
            alu_status = VEC_ALU_NOP;
            check("s5_hold_valid", 64'(wb_valid), 64'd1);
            check("s5_hold_beat",  64'(wb_beat),  64'd1);
            check("s5_hold_data",  wb_data,       pat[127:64]);
            check("s5_hold_index", 64'(wb_index), 64'd21);
            check("s5_ovr",        64'(overrun),  64'd1);
        end
        wb_ready = 1'b1;
        tick();
        check("s5_beat2_num",  64'(wb_beat), 64'd2);
        check("s5_beat2_data", wb_data,      pat[191:128]);
        tick();
        check("s5_beat3_data", wb_data,      pat[255:192]);
        tick();
        check("s5_done",       64'(wb_done), 64'd1);
        check("s5_ovr_sticky", 64'(overrun), 64'd1);
        tick();

        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("rst2_ovr", 64'(overrun), 64'd0);
        tick();

        // vl=0 writes old_vd (or all-ones tail) over all beats; FINISHED edge in DONE
        pat = {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}};
        start(FOUR_BYTE, 4'd0, 1'b1, 1'b0, '1 , pat, '0, 5'd12);
        tick();
`ifdef VWB_TAIL_AGNOSTIC_EN
        exp_vec = '1;
`else
        exp_vec = pat;
`endif
        stream("s6", exp_vec, 5'd12);
        check("s6_done", 64'(wb_done), 64'd1);
        alu_status = VEC_ALU_FINISHED;
        tick();
        alu_status = VEC_ALU_NOP;
        check("s6_done_ovr",  64'(overrun), 64'd1);
        check("s6_idle_busy", 64'(busy),    64'd0);
        tick();
        check("s6_discarded", 64'(busy),    64'd0);

        // reset during beat 2
        start(FOUR_BYTE, 4'd8, 1'b1, 1'b0, {32{8'h5A}}, '0, '0, 5'd30);
        tick(); tick(); tick();
        check("s7_pre_beat", 64'(wb_beat),  64'd2);
        rst = 1'b0;
        #1;
        check("s7_rst_valid", 64'(wb_valid), 64'd0);
        check("s7_rst_busy",  64'(busy),     64'd0);
        check("s7_rst_ovr",   64'(overrun),  64'd0);
        check("s7_rst_data",  wb_data,       64'd0);
        tick();
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            tick();
            check("s7_quiet", 64'({wb_valid, wb_done, busy}), 64'd0);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
